// File: rtl/seg7_hex_capture.sv
// seg7_hex_capture: recovers hex nibbles from a multiplexed active-low 7-segment bus
// and hands out complete frames on a valid/ready port, with one frame of buffering.
module seg7_hex_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    overrun
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned VAL_W = NIB_W * NUM_DIGITS;
  localparam int unsigned SMP_W = NUM_DIGITS + SEG_W;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [NUM_DIGITS-1:0]  an_q;
  logic [SEG_W-1:0]       seg_q;
  logic [SMP_W-1:0]       prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [VAL_W-1:0]       slot_val_q;
  logic [NUM_DIGITS-1:0]  slot_err_q;
  logic [NUM_DIGITS-1:0]  seen_q;

  logic [SMP_W-1:0]       sample_c;
  logic                   legal_c;
  logic                   changed_c;
  logic [CNT_W-1:0]       cnt_nxt_c;
  logic                   capture_c;
  logic [NUM_DIGITS-1:0]  cap_mask_c;
  logic [NIB_W-1:0]       dec_nib_c;
  logic                   dec_err_c;
  logic                   seen_full_c;
  logic                   load_c;
  logic                   drop_c;
  logic                   valid_d;

  // Segment pattern to {err, nibble}; anything outside the hex font is an error.
  function automatic logic [NIB_W:0] decode(input logic [SEG_W-1:0] s);
    case (s)
      7'b0000001: decode = {1'b0, 4'h0};
      7'b1001111: decode = {1'b0, 4'h1};
      7'b0010010: decode = {1'b0, 4'h2};
      7'b0000110: decode = {1'b0, 4'h3};
      7'b1001100: decode = {1'b0, 4'h4};
      7'b0100100: decode = {1'b0, 4'h5};
      7'b0100000: decode = {1'b0, 4'h6};
      7'b0001111: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0000100: decode = {1'b0, 4'h9};
      7'b0001000: decode = {1'b0, 4'hA};
      7'b1100000: decode = {1'b0, 4'hB};
      7'b0110001: decode = {1'b0, 4'hC};
      7'b1000010: decode = {1'b0, 4'hD};
      7'b0110000: decode = {1'b0, 4'hE};
      7'b0111000: decode = {1'b0, 4'hF};
      default:    decode = {1'b1, 4'h0};
    endcase
  endfunction

  // Input stage: everything downstream works on these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      seg_q  <= 7'h7F;
      prev_q <= {{NUM_DIGITS{1'b1}}, 7'h7F};
      cnt_q  <= '0;
    end else begin
      an_q   <= an;
      seg_q  <= seg;
      prev_q <= sample_c;
      cnt_q  <= cnt_nxt_c;
    end
  end

  assign sample_c  = {an_q, seg_q};
  assign legal_c   = $onehot(~an_q);
  // A zero count means the previous sample was not a legal digit, so treat as new.
  assign changed_c = (sample_c != prev_q) || (cnt_q == '0);

  // Saturating stability counter; capture fires on the cycle it first hits the target.
  always_comb begin
    cnt_nxt_c = '0;
    capture_c = 1'b0;
    if (legal_c) begin
      if (changed_c) begin
        cnt_nxt_c = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_nxt_c = cnt_q + CNT_W'(1);
      end else begin
        cnt_nxt_c = cnt_q;
      end
      capture_c = (cnt_nxt_c == CNT_MAX) && (changed_c || (cnt_q != CNT_MAX));
    end
  end

  assign cap_mask_c             = capture_c ? ~an_q : '0;
  assign {dec_err_c, dec_nib_c} = decode(seg_q);
  assign seen_full_c            = &seen_q;

  // Collect slots: the capture buffer that keeps filling while a frame is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_val_q <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (cap_mask_c[i]) begin
          slot_val_q[NIB_W*i +: NIB_W] <= dec_nib_c;
          slot_err_q[i]                <= dec_err_c;
        end
      end
      seen_q <= ((load_c || drop_c) ? '0 : seen_q) | cap_mask_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load a completed frame, or drop it if the held one is not taken.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    drop_c  = 1'b0;
    valid_d = frame_valid;
    case (state_q)
      COLLECT: begin
        if (seen_full_c) begin
          load_c  = 1'b1;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_valid && frame_ready) begin
          if (seen_full_c) begin
            load_c  = 1'b1;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = COLLECT;
          end
        end else if (seen_full_c) begin
          drop_c = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_value <= '0;
      frame_err   <= '0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= valid_d;
      overrun     <= overrun | drop_c;
      if (load_c) begin
        frame_value <= slot_val_q;
        frame_err   <= slot_err_q;
      end
    end
  end

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Bench for seg7_hex_capture: directed scenarios plus a randomized digit stream
// checked against a per-hold-interval reference model.
module tb_seg7_hex_capture;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_r;
  logic [ND-1:0] an_r;
  logic          frame_ready;
  logic          frame_valid;
  logic [4*ND-1:0] frame_value;
  logic [ND-1:0] frame_err;
  logic          overrun;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [19:0] obs_q [$];
  int unsigned vcount = 0;

  always #5 clk = ~clk;

  seg7_hex_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg_r),
    .an          (an_r),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_value (frame_value),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  // Record every accepted frame and every cycle with frame_valid high.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      vcount <= vcount + 1;
      if (frame_ready) obs_q.push_back({frame_err, frame_value});
    end
  end

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    ref_decode = 5'h10;
    for (int k = 0; k < 16; k++)
      if (seg_tab[k] == s) ref_decode = {1'b0, 4'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [ND-1:0] a, input logic [6:0] s, input int n);
    an_r  = a;
    seg_r = s;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an_r = '1;
    seg_r = 7'h7F;
    frame_ready = 1'b1;
    repeat (3) tick();
    total++; if (frame_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", frame_valid); else passed++;
    total++; if (frame_value !== 16'h0) $display("FAIL reset_value: got %h want 0000", frame_value); else passed++;
    total++; if (frame_err !== 4'h0) $display("FAIL reset_err: got %b want 0000", frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int unsigned v0;
    int first;
    logic [15:0] val;
    logic [3:0] err;
    v0 = vcount;
    first = 0;
    val = 'x;
    err = 'x;
    drive(4'b0111, seg_tab[1], 8);
    drive(4'b1011, seg_tab[2], 8);
    drive(4'b1101, seg_tab[3], 8);
    an_r = 4'b1110;
    seg_r = seg_tab[4];
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (frame_valid && first == 0) begin
        first = c;
        val = frame_value;
        err = frame_err;
      end
    end
    drive(4'b1111, 7'h7F, 4);
    total++; if (first != 6) $display("FAIL basic_latency: got %0d edges want 6", first); else passed++;
    total++; if (val !== 16'h1234) $display("FAIL basic_value: got %h want 1234", val); else passed++;
    total++; if (err !== 4'h0) $display("FAIL basic_err: got %b want 0000", err); else passed++;
    total++; if (vcount - v0 != 1) $display("FAIL basic_valid_width: got %0d cycles want 1", vcount - v0); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_short_hold();
    int unsigned v0;
    int unsigned o0;
    v0 = vcount;
    o0 = obs_q.size();
    drive(4'b0111, seg_tab[1], 8);
    drive(4'b1011, seg_tab[2], 8);
    drive(4'b1101, seg_tab[3], 8);
    drive(4'b1110, seg_tab[0], 3);
    drive(4'b1111, 7'h7F, 10);
    total++; if (vcount != v0) $display("FAIL short_no_frame: got %0d valid cycles want 0", vcount - v0); else passed++;
    drive(4'b1110, seg_tab[0], 4);
    drive(4'b1111, 7'h7F, 6);
    total++; if (obs_q.size() - o0 != 1) $display("FAIL short_frame_count: got %0d want 1", obs_q.size() - o0); else passed++;
    total++; if (obs_q.size() > o0 && obs_q[o0] !== {4'h0, 16'h1230})
      $display("FAIL short_frame: got %h want %h", obs_q[o0], {4'h0, 16'h1230}); else passed++;
  endtask

  task automatic test_err();
    int unsigned o0;
    o0 = obs_q.size();
    drive(4'b0111, seg_tab[10], 8);
    drive(4'b1011, seg_tab[11], 8);
    drive(4'b1101, seg_tab[12], 8);
    drive(4'b1110, 7'b1111111, 8);
    drive(4'b1111, 7'h7F, 6);
    total++; if (obs_q.size() - o0 != 1) $display("FAIL err_frame_count: got %0d want 1", obs_q.size() - o0); else passed++;
    total++; if (frame_err !== 4'b0001) $display("FAIL err_mask: got %b want 0001", frame_err); else passed++;
    total++; if (frame_value !== 16'hABC0) $display("FAIL err_value: got %h want abc0", frame_value); else passed++;
  endtask

  task automatic test_illegal();
    int unsigned v0;
    int unsigned o0;
    v0 = vcount;
    o0 = obs_q.size();
    drive(4'b0111, seg_tab[5], 8);
    drive(4'b1011, seg_tab[6], 8);
    drive(4'b1101, seg_tab[7], 8);
    drive(4'b1100, seg_tab[8], 20);
    total++; if (vcount != v0) $display("FAIL illegal_multi: got %0d valid cycles want 0", vcount - v0); else passed++;
    drive(4'b1111, seg_tab[8], 20);
    drive(4'b0011, seg_tab[8], 20);
    total++; if (vcount != v0) $display("FAIL illegal_blank: got %0d valid cycles want 0", vcount - v0); else passed++;
    drive(4'b1110, seg_tab[9], 8);
    drive(4'b1111, 7'h7F, 6);
    total++; if (obs_q.size() - o0 != 1) $display("FAIL illegal_frame_count: got %0d want 1", obs_q.size() - o0); else passed++;
    total++; if (obs_q.size() > o0 && obs_q[o0] !== {4'h0, 16'h5679})
      $display("FAIL illegal_frame: got %h want %h", obs_q[o0], {4'h0, 16'h5679}); else passed++;
  endtask

  task automatic test_overrun();
    int unsigned o0;
    frame_ready = 1'b0;
    drive(4'b0111, seg_tab[13], 8);
    drive(4'b1011, seg_tab[14], 8);
    drive(4'b1101, seg_tab[15], 8);
    drive(4'b1110, seg_tab[8], 8);
    drive(4'b1111, 7'h7F, 4);
    total++; if (frame_valid !== 1'b1 || frame_value !== 16'hDEF8)
      $display("FAIL ovr_first: got valid=%b value=%h want 1/def8", frame_valid, frame_value); else passed++;
    drive(4'b0111, seg_tab[4], 8);
    drive(4'b1011, seg_tab[3], 8);
    drive(4'b1101, seg_tab[2], 8);
    drive(4'b1110, seg_tab[1], 8);
    drive(4'b1111, 7'h7F, 4);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    total++; if (frame_valid !== 1'b1 || frame_value !== 16'hDEF8 || frame_err !== 4'h0)
      $display("FAIL ovr_retained: got valid=%b value=%h err=%b want 1/def8/0000", frame_valid, frame_value, frame_err); else passed++;
    o0 = obs_q.size();
    frame_ready = 1'b1;
    tick();
    total++; if (frame_valid !== 1'b0) $display("FAIL ovr_accept: got valid=%b want 0", frame_valid); else passed++;
    total++; if (obs_q.size() - o0 != 1 || obs_q[obs_q.size()-1] !== {4'h0, 16'hDEF8})
      $display("FAIL ovr_accepted_frame: got count=%0d want 1 of def8", obs_q.size() - o0); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
  endtask

  task automatic test_reset_mid();
    int unsigned o0;
    drive(4'b0111, seg_tab[9], 8);
    drive(4'b1011, seg_tab[10], 8);
    drive(4'b1101, seg_tab[11], 2);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (frame_value !== 16'h0 || frame_valid !== 1'b0 || frame_err !== 4'h0)
      $display("FAIL rstmid_outputs: got valid=%b value=%h err=%b want 0", frame_valid, frame_value, frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b want 0", overrun); else passed++;
    tick();
    an_r = '1;
    seg_r = 7'h7F;
    tick();
    rst_n = 1'b1;
    tick();
    o0 = obs_q.size();
    drive(4'b1101, seg_tab[1], 8);
    drive(4'b1110, seg_tab[2], 8);
    drive(4'b1111, 7'h7F, 6);
    total++; if (obs_q.size() != o0) $display("FAIL rstmid_partial_kept: got %0d frames want 0", obs_q.size() - o0); else passed++;
    drive(4'b0111, seg_tab[9], 8);
    drive(4'b1011, seg_tab[10], 8);
    drive(4'b1111, 7'h7F, 6);
    total++; if (obs_q.size() - o0 != 1 || obs_q[obs_q.size()-1] !== {4'h0, 16'h9A12})
      $display("FAIL rstmid_frame: got count=%0d last=%h want 1 of 09a12", obs_q.size() - o0,
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 20'h0); else passed++;
  endtask

  task automatic test_random();
    logic [19:0] exp_q [$];
    logic [15:0] m_val;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic [10:0] prev;
    logic [ND-1:0] a;
    logic [6:0] s;
    logic [4:0] d;
    int n;
    int idx;
    int unsigned o0;
    int unsigned nobs;
    frame_ready = 1'b1;
    m_val = '0;
    m_err = '0;
    m_seen = '0;
    prev = {4'hF, 7'h7F};
    o0 = obs_q.size();
    for (int e = 0; e < 160; e++) begin
      do begin
        case ($urandom % 10)
          8:       a = 4'hF;
          9:       a = 4'($urandom);
          default: a = ~(4'b0001 << ($urandom % 4));
        endcase
        s = (($urandom % 4) == 0) ? 7'($urandom) : seg_tab[$urandom % 16];
      end while ({a, s} == prev);
      n = int'($urandom_range(1, 7));
      drive(a, s, n);
      prev = {a, s};
      if ($onehot(~a) && n >= int'(SC)) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) idx = k;
        d = ref_decode(s);
        m_val[4*idx +: 4] = d[3:0];
        m_err[idx] = d[4];
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
          exp_q.push_back({m_err, m_val});
          m_seen = '0;
        end
      end
    end
    drive(4'b1111, 7'h7F, 8);
    nobs = obs_q.size() - o0;
    total++; if (nobs != exp_q.size()) $display("FAIL rand_frame_count: got %0d want %0d", nobs, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < int'(nobs); i++) begin
      total++;
      if (obs_q[o0 + i] !== exp_q[i]) $display("FAIL rand_frame_%0d: got %h want %h", i, obs_q[o0 + i], exp_q[i]);
      else passed++;
    end
    total++; if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b want 0", overrun); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    an_r = '1;
    seg_r = 7'h7F;
    frame_ready = 1'b1;
    test_reset();
    test_basic();
    test_short_hold();
    test_err();
    test_illegal();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
